mbist_march_ctrl: RTL and testbench



---
 rtl/mbist_march_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences reads/writes over addresses 0..DEPTH-1 and checks rdata.
// Optional first-failure capture (fail_addr/fail_data) is enabled by defining MBIST_FAIL_LOG_EN.
module mbist_march_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  mem_write_read,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MBIST_FAIL_LOG_EN
    ,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RD,
        S_WR,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [DATA_WIDTH-1:0] ONES      = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] ZEROS     = '0;

    state_t                r_state;
    logic [2:0]            r_elem;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_drain;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_fail;
    logic [CNT_WIDTH-1:0]  r_failCount;
    logic [1:0]            r_pipeValid;
    logic [DATA_WIDTH-1:0] r_pipeExp0;
    logic [DATA_WIDTH-1:0] r_pipeExp1;

    state_t                w_nextState;
    logic [2:0]            w_nextElem;
    logic [ADDR_WIDTH-1:0] w_nextAddr;
    logic [DATA_WIDTH-1:0] w_nextWdata;
    logic                  w_nextDrain;
    logic                  w_down;
    logic                  w_lastAddr;
    logic [ADDR_WIDTH-1:0] w_stepAddr;
    logic [DATA_WIDTH-1:0] w_expRead;
    logic                  w_accept;
    logic                  w_finish;
    logic                  w_mismatch;

    // E1 and E3 write all-ones; every other element writes all-zeros.
    function automatic logic [DATA_WIDTH-1:0] writeValue(input logic [2:0] elem);
        return (elem == 3'd1 || elem == 3'd3) ? ONES : ZEROS;
    endfunction

    assign w_down     = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_lastAddr = w_down ? (r_addr == '0) : (r_addr == LAST_ADDR);
    assign w_stepAddr = w_down ? (r_addr - ADDR_WIDTH'(1)) : (r_addr + ADDR_WIDTH'(1));
    assign w_expRead  = (r_elem == 3'd2 || r_elem == 3'd4) ? ONES : ZEROS;
    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_finish   = (r_state == S_DRAIN) && r_drain;
    assign w_mismatch = r_pipeValid[1] && (mem_rdata != r_pipeExp1);

    always_comb begin
        w_nextState = r_state;
        w_nextElem  = r_elem;
        w_nextAddr  = r_addr;
        w_nextWdata = r_wdata;
        w_nextDrain = r_drain;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = S_SETUP;
                    w_nextElem  = 3'd0;
                    w_nextWdata = writeValue(3'd0);
                end
            end
            S_SETUP: begin
                w_nextAddr  = w_down ? LAST_ADDR : '0;
                w_nextState = (r_elem == 3'd0) ? S_WR : S_RD;
            end
            S_RD: begin
                if (r_elem != 3'd5) begin
                    w_nextState = S_WR;
                end else if (w_lastAddr) begin
                    w_nextState = S_DRAIN;
                    w_nextDrain = 1'b0;
                end else begin
                    w_nextAddr = w_stepAddr;
                end
            end
            S_WR: begin
                if (w_lastAddr) begin
                    w_nextState = S_SETUP;
                    w_nextElem  = r_elem + 3'd1;
                    // The final read-only element keeps the previous write value.
                    if (r_elem != 3'd4) begin
                        w_nextWdata = writeValue(r_elem + 3'd1);
                    end
                end else begin
                    w_nextAddr  = w_stepAddr;
                    w_nextState = (r_elem == 3'd0) ? S_WR : S_RD;
                end
            end
            S_DRAIN: begin
                if (r_drain) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextDrain = 1'b1;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_elem  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_drain <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_elem  <= w_nextElem;
            r_addr  <= w_nextAddr;
            r_wdata <= w_nextWdata;
            r_drain <= w_nextDrain;
        end
    end

    // Expected data rides two stages so it lines up with the memory's 2-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipeValid <= '0;
            r_pipeExp0  <= '0;
            r_pipeExp1  <= '0;
        end else begin
            r_pipeValid <= {r_pipeValid[0], (r_state == S_RD)};
            r_pipeExp0  <= w_expRead;
            r_pipeExp1  <= r_pipeExp0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_failCount <= '0;
        end else if (w_accept) begin
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_fail      <= 1'b0;
            r_failCount <= '0;
        end else begin
            if (w_finish) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_mismatch) begin
                r_fail <= 1'b1;
                if (r_failCount != {CNT_WIDTH{1'b1}}) begin
                    r_failCount <= r_failCount + CNT_WIDTH'(1);
                end
            end
        end
    end

`ifdef MBIST_FAIL_LOG_EN
    logic [ADDR_WIDTH-1:0] r_pipeAddr0;
    logic [ADDR_WIDTH-1:0] r_pipeAddr1;
    logic [ADDR_WIDTH-1:0] r_failAddr;
    logic [DATA_WIDTH-1:0] r_failData;

    // fail is still clear on the first mismatch of a run, so it gates the capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipeAddr0 <= '0;
            r_pipeAddr1 <= '0;
            r_failAddr  <= '0;
            r_failData  <= '0;
        end else begin
            r_pipeAddr0 <= r_addr;
            r_pipeAddr1 <= r_pipeAddr0;
            if (w_accept) begin
                r_failAddr <= '0;
                r_failData <= '0;
            end else if (w_mismatch && !r_fail) begin
                r_failAddr <= r_pipeAddr1;
                r_failData <= mem_rdata;
            end
        end
    end

    assign fail_addr = r_failAddr;
    assign fail_data = r_failData;
`endif

    assign busy           = r_busy;
    assign done           = r_done;
    assign fail           = r_fail;
    assign fail_count     = r_failCount;
    assign mem_write_read = (r_state == S_WR);
    assign mem_address    = r_addr;
    assign mem_wdata      = r_wdata;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: two instances (8-bit and 6-bit fail counters) on behavioural faulty memories.
// An abstract March C- walk over a copy of the memory predicts the mismatch results of each run.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;

    logic       busyA, doneA, failA;
    logic [7:0] cntA;
    logic       busyB, doneB, failB;
    logic [5:0] cntB;
    logic [1:0] memWe;
    logic [3:0] memAddr [2];
    logic [7:0] memWdata [2];
    logic [7:0] memRdata [2];
    logic [7:0] mem [2][16];
    logic [7:0] wReg [2];
    logic [7:0] s1 [2];
    logic [7:0] snap [16];

    // Fault model: 0 none, 1 stuck bit on read, 2 write-transition coupling, 3 all reads inverted.
    int         faultMode = 0;
    logic [3:0] fAddr = '0;
    logic [3:0] fVictim = '0;
    int         fBit = 0;
    logic       fVal = 1'b0;

    int         vecCount = 0;
    int         missCount = 0;
    int         runCycles;
    int         runWrites;

`ifdef MBIST_FAIL_LOG_EN
    logic [3:0] failAddrA, failAddrB;
    logic [7:0] failDataA, failDataB;
`endif

    always #5 clk = ~clk;

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .CNT_WIDTH(8)) dutA (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busyA), .done(doneA), .fail(failA), .fail_count(cntA),
        .mem_write_read(memWe[0]), .mem_address(memAddr[0]),
        .mem_wdata(memWdata[0]), .mem_rdata(memRdata[0])
`ifdef MBIST_FAIL_LOG_EN
        , .fail_addr(failAddrA), .fail_data(failDataA)
`endif
    );

    mbist_march_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DEPTH(16), .CNT_WIDTH(6)) dutB (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busyB), .done(doneB), .fail(failB), .fail_count(cntB),
        .mem_write_read(memWe[1]), .mem_address(memAddr[1]),
        .mem_wdata(memWdata[1]), .mem_rdata(memRdata[1])
`ifdef MBIST_FAIL_LOG_EN
        , .fail_addr(failAddrB), .fail_data(failDataB)
`endif
    );

    function automatic logic [7:0] faultRead(input logic [3:0] a, input logic [7:0] v);
        logic [7:0] r;
        r = v;
        if (faultMode == 1 && a == fAddr) r[fBit] = fVal;
        if (faultMode == 3) r = ~v;
        return r;
    endfunction

    // Memory: write uses last cycle's wdata; read data returns two cycles after the read address.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (memWe[k]) begin
                if (faultMode == 2 && memAddr[k] == fAddr && mem[k][fAddr] != wReg[k])
                    mem[k][fVictim][fBit] <= ~mem[k][fVictim][fBit];
                mem[k][memAddr[k]] <= wReg[k];
            end
            wReg[k]     <= memWdata[k];
            s1[k]       <= faultRead(memAddr[k], mem[k][memAddr[k]]);
            memRdata[k] <= s1[k];
        end
    end

    task automatic checkOutput(input string name, input int unsigned act, input int unsigned exp);
        vecCount++;
        if (act != exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Abstract March C- walk: elements, directions and data values straight from the algorithm.
    task automatic refModel(output int cnt, output int fa, output int fd);
        logic [7:0] m [16];
        logic [7:0] got, expv, wv;
        cnt = 0; fa = 0; fd = 0;
        for (int i = 0; i < 16; i++) m[i] = snap[i];
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 16; i++) begin
                int a = (e == 3 || e == 4) ? 15 - i : i;
                if (e > 0) begin
                    expv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
                    got  = faultRead(a[3:0], m[a]);
                    if (got != expv) begin
                        if (cnt == 0) begin fa = a; fd = int'(got); end
                        cnt++;
                    end
                end
                if (e < 5) begin
                    wv = (e == 1 || e == 3) ? 8'hFF : 8'h00;
                    if (faultMode == 2 && a[3:0] == fAddr && m[a] != wv) m[fVictim][fBit] = ~m[fVictim][fBit];
                    m[a] = wv;
                end
            end
        end
    endtask

    // One run: pulse start, optionally re-pulse or abort with reset, count cycles until done.
    task automatic applyStimulus(input int extraStartAt, input int abortAt, output bit aborted);
        aborted = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 16; i++) snap[i] = mem[0][i];
        checkOutput("busy after accept", busyA, 1);
        checkOutput("done cleared on accept", doneA, 0);
        checkOutput("fail cleared on accept", {failA, cntA}, 0);
        runCycles = 0;
        runWrites = 0;
        while (runCycles < 400) begin
            if (memWe[0]) runWrites++;
            if (doneA) break;
            @(negedge clk);
            runCycles++;
            start = (runCycles == extraStartAt);
            if (runCycles == abortAt) begin
                rst_n = 1'b0;
                #1;
                checkOutput("outputs after async reset",
                            {busyA, doneA, failA, cntA, memWe[0], memAddr[0], memWdata[0]}, 0);
                @(negedge clk) rst_n = 1'b1;
                start = 1'b0;
                aborted = 1;
                return;
            end
        end
        start = 1'b0;
    endtask

    task automatic checkRun(input string tag, input int expFail, input int expCnt,
                            input int expFa, input int expFd);
        int sat6;
        sat6 = (expCnt > 63) ? 63 : expCnt;
        checkOutput({tag, " cycles to done"}, runCycles, 168);
        checkOutput({tag, " write cycles"}, runWrites, 80);
        checkOutput({tag, " busy/done at end"}, {busyA, doneA, busyB, doneB}, 4'b0101);
        checkOutput({tag, " fail"}, {failA, failB}, expFail ? 3 : 0);
        checkOutput({tag, " fail_count w8"}, cntA, (expCnt > 255) ? 255 : expCnt);
        checkOutput({tag, " fail_count w6"}, cntB, sat6);
`ifdef MBIST_FAIL_LOG_EN
        checkOutput({tag, " fail_addr"}, failAddrA, expFa);
        checkOutput({tag, " fail_data"}, failDataA, expFd);
`endif
    endtask

    typedef struct {
        int mode;
        int addr;
        int bitIdx;
        int val;
        int expFail;
        int expCnt;
        int expFa;
        int expFd;
    } vec_t;

    initial begin
        vec_t vecs [4];
        bit   ab;
        int   rc, rfa, rfd;

        vecs[0] = '{0, 0,  0, 0, 0, 0,  0,  8'h00};
        vecs[1] = '{1, 5,  3, 0, 1, 2,  5,  8'hF7};
        vecs[2] = '{3, 0,  0, 0, 1, 80, 0,  8'hFF};
        vecs[3] = '{1, 10, 0, 1, 1, 3,  10, 8'h01};

        #12;
        checkOutput("reset state",
                    {busyA, doneA, failA, cntA, memWe[0], memAddr[0], memWdata[0], busyB, doneB, failB, cntB}, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            faultMode = vecs[v].mode;
            fAddr     = 4'(vecs[v].addr);
            fBit      = vecs[v].bitIdx;
            fVal      = vecs[v].val[0];
            applyStimulus(0, 0, ab);
            checkRun($sformatf("vec%0d", v), vecs[v].expFail, vecs[v].expCnt, vecs[v].expFa, vecs[v].expFd);
        end

        // Reset 50 cycles into a stuck-at run, then a complete run afterwards.
        faultMode = 1; fAddr = 4'd5; fBit = 3; fVal = 1'b0;
        applyStimulus(0, 50, ab);
        checkOutput("abort taken", ab, 1);
        applyStimulus(0, 0, ab);
        checkRun("after abort", 1, 2, 5, 8'hF7);

        // Start re-pulsed mid-run is ignored; a following run repeats identically.
        applyStimulus(20, 0, ab);
        checkRun("start while busy", 1, 2, 5, 8'hF7);
        applyStimulus(0, 0, ab);
        checkRun("second run", 1, 2, 5, 8'hF7);

        for (int r = 0; r < 8; r++) begin
            faultMode = (r % 2 == 0) ? 2 : 1;
            fAddr     = 4'($urandom_range(4, 11));
            fVictim   = 4'($urandom_range(0, 15));
            if (fVictim == fAddr) fVictim = fAddr ^ 4'd8;
            fBit      = int'($urandom_range(0, 7));
            fVal      = 1'($urandom_range(0, 1));
            applyStimulus(0, 0, ab);
            refModel(rc, rfa, rfd);
            checkRun($sformatf("rand%0d mode%0d", r, faultMode), (rc > 0) ? 1 : 0, rc, rfa, rfd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
